// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite decoder + response mux: HSEL and mux are combinational, data-phase owner is registered (1 cycle), unmapped NONSEQ/SEQ get a 2-cycle ERROR.
// A slave wait state stalls the owner register. Decode-error statistics are built only with AHB_DEC_ERRSTAT_EN defined.
module ahblite_decoder_mux #(
    parameter int                   NPORTS    = 8,
    parameter logic [NPORTS*32-1:0] BASE_ADDR = {32'h4004_0000, 32'h4003_0000, 32'h4002_0000, 32'h4001_0000,
                                                 32'h4000_0010, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NPORTS*32-1:0] ADDR_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                                 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter logic [NPORTS-1:0]    PORT_EN   = '1
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    output logic [NPORTS-1:0]      HSEL,
    input  logic [NPORTS*32-1:0]   S_HRDATA,
    input  logic [NPORTS-1:0]      S_HREADYOUT,
    input  logic [NPORTS-1:0]      S_HRESP,
    output logic [31:0]            HRDATA,
    output logic                   HREADY,
    output logic                   HRESP,
    output logic [15:0]            ERR_COUNT,
    output logic [31:0]            ERR_ADDR
);

    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

    logic [NPORTS-1:0] w_hsel;
    logic              w_hit;
    logic              w_unmapped;
    logic              w_unused;

    logic [NPORTS-1:0] r_sel_d;
    logic              r_dflt_d;
    state_t            r_state;
    logic              r_err_rdy;
    logic              r_err_resp;

    // Lowest-index enabled match wins, so overlapping regions resolve deterministically.
    always_comb begin
        w_hsel = '0;
        w_hit  = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!w_hit && PORT_EN[i] &&
                ((HADDR & ADDR_MASK[i*32 +: 32]) == (BASE_ADDR[i*32 +: 32] & ADDR_MASK[i*32 +: 32]))) begin
                w_hsel[i] = 1'b1;
                w_hit     = 1'b1;
            end
        end
    end

    assign HSEL       = w_hsel;
    assign w_unmapped = ~w_hit & HTRANS[1];
    assign w_unused   = HTRANS[0];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_sel_d    <= '0;
            r_dflt_d   <= 1'b0;
            r_state    <= ST_IDLE;
            r_err_rdy  <= 1'b1;
            r_err_resp <= 1'b0;
        end else begin
            if (HREADY) begin
                r_sel_d  <= w_hsel;
                r_dflt_d <= w_unmapped;
            end
            case (r_state)
                ST_ERR1: begin
                    r_state    <= ST_ERR2;
                    r_err_rdy  <= 1'b1;
                    r_err_resp <= 1'b1;
                end
                default: begin
                    // ERR2 always has HREADY=1, so a fresh unmapped phase chains straight into ERR1.
                    if (HREADY && w_unmapped) begin
                        r_state    <= ST_ERR1;
                        r_err_rdy  <= 1'b0;
                        r_err_resp <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_err_rdy  <= 1'b1;
                        r_err_resp <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (r_dflt_d) begin
            HREADY = r_err_rdy;
            HRESP  = r_err_resp;
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (r_sel_d[i]) begin
                HRDATA = S_HRDATA[i*32 +: 32];
                HREADY = S_HREADYOUT[i];
                HRESP  = S_HRESP[i];
            end
        end
    end

`ifdef AHB_DEC_ERRSTAT_EN
    logic [15:0] r_err_count;
    logic [31:0] r_err_addr;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else if (HREADY && w_unmapped) begin
            if (r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
            r_err_addr <= HADDR;
        end
    end

    assign ERR_COUNT = r_err_count;
    assign ERR_ADDR  = r_err_addr;
`else
    assign ERR_COUNT = '0;
    assign ERR_ADDR  = '0;
`endif

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Bench for ahblite_decoder_mux: directed scenarios then random traffic against a transaction-level model.
module tb_ahblite_decoder_mux;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic [31:0]  HADDR = '0;
    logic [1:0]   HTRANS = '0;
    logic [255:0] S_HRDATA = '0;
    logic [7:0]   S_HREADYOUT = '1;
    logic [7:0]   S_HRESP = '0;
    logic [7:0]   HSEL;
    logic [31:0]  HRDATA;
    logic         HREADY;
    logic         HRESP;
    logic [15:0]  ERR_COUNT;
    logic [31:0]  ERR_ADDR;
    logic [7:0]   p_hsel;
    logic [31:0]  p_hrdata;
    logic         p_hready;
    logic         p_hresp;
    logic [15:0]  p_err_count;
    logic [31:0]  p_err_addr;

    always #5 HCLK = ~HCLK;

    ahblite_decoder_mux u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .ERR_COUNT(ERR_COUNT), .ERR_ADDR(ERR_ADDR)
    );

    ahblite_decoder_mux #(.PORT_EN(8'hFE)) u_dut_pe (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(p_hsel),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .HRDATA(p_hrdata), .HREADY(p_hready), .HRESP(p_hresp), .ERR_COUNT(p_err_count), .ERR_ADDR(p_err_addr)
    );

    logic [31:0] base_t [0:7] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h4000_0010,
                                  32'h4001_0000, 32'h4002_0000, 32'h4003_0000, 32'h4004_0000};
    logic [31:0] mask_t [0:7] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                  32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    logic [31:0] alist  [0:9] = '{32'h0000_0100, 32'h2000_0010, 32'h4000_0004, 32'h4000_0014, 32'h4000_0020,
                                  32'h3000_0000, 32'h4001_1234, 32'h4004_FFFC, 32'h4005_0000, 32'h1000_0000};

    int          checks = 0;
    int          failures = 0;
    int          m_owner = -1;   // port owning the data phase, -1 when none
    int          m_err = 0;      // 0 no error, 1/2 = first/second error cycle
    bit          m_known = 0;
    bit          rnd_data = 0;
    logic        exp_rdy = 1'b1;
    logic [15:0] m_cnt = '0;
    logic [31:0] m_addr = '0;

    function automatic int decode(input logic [31:0] a, input logic [7:0] en);
        for (int i = 0; i < 8; i++) begin
            if (en[i] && ((a & mask_t[i]) == (base_t[i] & mask_t[i]))) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rstn, input logic [31:0] addr, input logic [1:0] trans, input logic [7:0] rdy);
        int          d;
        int          d2;
        logic [31:0] e_data;
        logic        e_resp;
        @(negedge HCLK);
        HRESETn     = rstn;
        HADDR       = addr;
        HTRANS      = trans;
        S_HREADYOUT = rdy;
        for (int k = 0; k < 8; k++) begin
            S_HRDATA[k*32 +: 32] = rnd_data ? $urandom : {16'hCAFE, 16'(k)};
        end
        S_HRESP = rnd_data ? 8'($urandom) : 8'h00;
        #1;
        d  = decode(addr, 8'hFF);
        d2 = decode(addr, 8'hFE);
        chk("hsel", {24'h0, HSEL}, (d >= 0) ? (32'h1 << d) : 32'h0);
        chk("hsel_pe", {24'h0, p_hsel}, (d2 >= 0) ? (32'h1 << d2) : 32'h0);
        if (m_owner >= 0) begin
            e_data  = S_HRDATA[m_owner*32 +: 32];
            exp_rdy = rdy[m_owner];
            e_resp  = S_HRESP[m_owner];
        end else begin
            e_data  = 32'h0;
            exp_rdy = (m_err != 1);
            e_resp  = (m_err != 0);
        end
        if (m_known) begin
            chk("hrdata", HRDATA, e_data);
            chk("hready", {31'h0, HREADY}, {31'h0, exp_rdy});
            chk("hresp", {31'h0, HRESP}, {31'h0, e_resp});
`ifdef AHB_DEC_ERRSTAT_EN
            chk("err_count", {16'h0, ERR_COUNT}, {16'h0, m_cnt});
            chk("err_addr", ERR_ADDR, m_addr);
`else
            chk("err_count", {16'h0, ERR_COUNT}, 32'h0);
            chk("err_addr", ERR_ADDR, 32'h0);
`endif
        end
    endtask

    task automatic tick();
        int d;
        bit unm;
        @(posedge HCLK);
        if (!HRESETn) begin
            m_owner = -1;
            m_err   = 0;
            m_cnt   = '0;
            m_addr  = '0;
            m_known = 1;
        end else if (exp_rdy) begin
            d       = decode(HADDR, 8'hFF);
            unm     = (d < 0) && HTRANS[1];
            m_owner = d;
            m_err   = unm ? 1 : 0;
            if (unm) begin
                if (m_cnt != 16'hFFFF) m_cnt++;
                m_addr = HADDR;
            end
        end else if (m_err == 1) begin
            m_err = 2;
        end
    endtask

    initial begin
        // Reset, then reset-state outputs.
        drive(1'b0, 32'h0, 2'b00, 8'hFF); tick();
        drive(1'b0, 32'h0, 2'b00, 8'hFF); tick();
        drive(1'b1, 32'h2000_0010, 2'b10, 8'hFF);
        chk("rst_hready", {31'h0, HREADY}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_err_count", {16'h0, ERR_COUNT}, 32'h0);
        chk("p1_hsel", {24'h0, HSEL}, 32'h02);
        tick();
        drive(1'b1, 32'h4000_0014, 2'b10, 8'hFF);
        chk("p1_rdata", HRDATA, 32'hCAFE_0001);
        chk("p1_resp", {31'h0, HRESP}, 32'h0);
        chk("p3_hsel", {24'h0, HSEL}, 32'h08);
        tick();
        drive(1'b1, 32'h4000_0004, 2'b10, 8'hFF);
        chk("p2_hsel", {24'h0, HSEL}, 32'h04);
        tick();

        // Port 2 stalls three cycles while port 0's address waits.
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 32'h0000_0100, 2'b10, 8'hFB);
            chk("stall_hready", {31'h0, HREADY}, 32'h0);
            tick();
        end
        drive(1'b1, 32'h0000_0100, 2'b10, 8'hFF);
        chk("stall_done_rdata", HRDATA, 32'hCAFE_0002);
        tick();
        drive(1'b1, 32'h4000_0020, 2'b00, 8'hFF);
        chk("p0_rdata", HRDATA, 32'hCAFE_0000);
        chk("boundary_hsel", {24'h0, HSEL}, 32'h0);
        tick();

        // Single unmapped NONSEQ.
        drive(1'b1, 32'h3000_0000, 2'b10, 8'hFF);
        chk("unm_hsel", {24'h0, HSEL}, 32'h0);
        tick();
        drive(1'b1, 32'h0, 2'b00, 8'hFF);
        chk("err1_hready", {31'h0, HREADY}, 32'h0);
        chk("err1_hresp", {31'h0, HRESP}, 32'h1);
        tick();
        drive(1'b1, 32'h0, 2'b00, 8'hFF);
        chk("err2_hready", {31'h0, HREADY}, 32'h1);
        chk("err2_hresp", {31'h0, HRESP}, 32'h1);
`ifdef AHB_DEC_ERRSTAT_EN
        chk("stat_count", {16'h0, ERR_COUNT}, 32'h1);
        chk("stat_addr", ERR_ADDR, 32'h3000_0000);
`endif
        tick();
        drive(1'b1, 32'h0, 2'b00, 8'hFF); tick();

        // Back-to-back unmapped transfers chain error pairs.
        drive(1'b1, 32'h3000_0000, 2'b10, 8'hFF); tick();
        drive(1'b1, 32'h3000_0004, 2'b10, 8'hFF); tick();
        drive(1'b1, 32'h3000_0004, 2'b10, 8'hFF);
        chk("b2b_err2_resp", {31'h0, HRESP}, 32'h1);
        tick();
        drive(1'b1, 32'h0, 2'b00, 8'hFF);
        chk("b2b_err1_hready", {31'h0, HREADY}, 32'h0);
        tick();
        drive(1'b1, 32'h0, 2'b00, 8'hFF); tick();
        drive(1'b1, 32'h0, 2'b00, 8'hFF); tick();

        // Reset asserted during ERR1.
        drive(1'b1, 32'h3000_0000, 2'b10, 8'hFF); tick();
        drive(1'b0, 32'h0, 2'b00, 8'hFF); tick();
        drive(1'b1, 32'h0, 2'b00, 8'hFF);
        chk("rst_err_hready", {31'h0, HREADY}, 32'h1);
        chk("rst_err_hresp", {31'h0, HRESP}, 32'h0);
        chk("rst_err_count", {16'h0, ERR_COUNT}, 32'h0);
        tick();

        // Instance with port 0 disabled: 0x0 NONSEQ errors, IDLE to unmapped does not.
        drive(1'b0, 32'h0, 2'b00, 8'hFF); tick();
        drive(1'b1, 32'h0, 2'b10, 8'hFF);
        chk("pe_hsel", {24'h0, p_hsel}, 32'h0);
        tick();
        drive(1'b1, 32'h3000_0000, 2'b00, 8'hFF);
        chk("pe_err1_hready", {31'h0, p_hready}, 32'h0);
        chk("pe_err1_hresp", {31'h0, p_hresp}, 32'h1);
        tick();
        drive(1'b1, 32'h3000_0000, 2'b00, 8'hFF);
        chk("pe_err2_hready", {31'h0, p_hready}, 32'h1);
        chk("pe_err2_hresp", {31'h0, p_hresp}, 32'h1);
        tick();
        drive(1'b1, 32'h3000_0000, 2'b00, 8'hFF);
        chk("pe_idle_hready", {31'h0, p_hready}, 32'h1);
        chk("pe_idle_hresp", {31'h0, p_hresp}, 32'h0);
`ifdef AHB_DEC_ERRSTAT_EN
        chk("pe_count", {16'h0, p_err_count}, 32'h1);
`endif
        tick();

        // Random traffic against the model.
        rnd_data = 1;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [7:0]  rdy;
            logic        rst;
            a   = ($urandom_range(0, 3) == 0) ? $urandom : alist[$urandom_range(0, 9)];
            rdy = 8'($urandom) | 8'($urandom);
            rst = ($urandom_range(0, 49) != 0);
            drive(rst, a, 2'($urandom), rdy);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
